// File: rtl/axis_corr_peak.sv
// axis_corr_peak: saturating-magnitude peak picker for the bit correlator stream.
// Each accepted beat carries NUM_PARALLEL signed samples. A beat whose largest
// magnitude reaches the threshold opens a SEARCH_BEATS-long window. The window
// tracks the earliest largest sample and emits one {index, magnitude} report,
// then ignores DEAD_BEATS beats.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Valid never waits on ready. Data is held stable while valid is high and
// ready is low.
module axis_corr_peak #(
    parameter int NUM_PARALLEL = 8,
    parameter int SLAVE_WIDTH  = 128,
    parameter int INDEX_WIDTH  = 16,
    parameter int SEARCH_BEATS = 4,
    parameter int DEAD_BEATS   = 2,
    parameter int VALUE_WIDTH  = SLAVE_WIDTH / NUM_PARALLEL,
    parameter int MASTER_WIDTH = INDEX_WIDTH + VALUE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VALUE_WIDTH-1:0]  threshold,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [SLAVE_WIDTH-1:0]  s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [MASTER_WIDTH-1:0] m_axis_tdata
);

    localparam int LANE_W = (NUM_PARALLEL > 1) ? $clog2(NUM_PARALLEL) : 1;
    localparam int WIN_W  = $clog2(SEARCH_BEATS + 1);
    localparam int DEAD_W = (DEAD_BEATS > 0) ? $clog2(DEAD_BEATS + 1) : 1;

    localparam logic [VALUE_WIDTH-1:0] MAG_MIN_NEG = {1'b1, {(VALUE_WIDTH-1){1'b0}}};
    localparam logic [VALUE_WIDTH-1:0] MAG_MAX_POS = {1'b0, {(VALUE_WIDTH-1){1'b1}}};
    localparam logic [WIN_W-1:0]       WIN_LAST    = WIN_W'(SEARCH_BEATS);
    localparam logic [DEAD_W-1:0]      DEAD_LAST   = DEAD_W'(DEAD_BEATS - 1);
    localparam logic [INDEX_WIDTH-1:0] BEAT_STEP   = INDEX_WIDTH'(NUM_PARALLEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Exposed by name so checkers can bind to the window state directly.
    state_t state;

    logic                   advance;
    logic [VALUE_WIDTH-1:0] lane_mag [NUM_PARALLEL];
    logic [VALUE_WIDTH-1:0] beat_max;
    logic [LANE_W-1:0]      beat_lane;

    logic [INDEX_WIDTH-1:0] sample_cnt;
    logic                   s1_valid;
    logic [VALUE_WIDTH-1:0] s1_max;
    logic [LANE_W-1:0]      s1_lane;
    logic [INDEX_WIDTH-1:0] s1_base;
    logic [INDEX_WIDTH-1:0] cand_idx;

    logic [WIN_W-1:0]       win_cnt;
    logic [DEAD_W-1:0]      dead_cnt;
    logic [INDEX_WIDTH-1:0] peak_idx;
    logic [VALUE_WIDTH-1:0] peak_mag;
    logic                   close_q;

    // The whole pipe moves only when the report slot is free or being drained.
    assign advance       = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = advance & ~rst;

    // Per-lane absolute value. The most negative code saturates to the largest positive code.
    always_comb begin
        for (int n = 0; n < NUM_PARALLEL; n++) begin
            lane_mag[n] = s_axis_tdata[n*VALUE_WIDTH +: VALUE_WIDTH];
            if (lane_mag[n] == MAG_MIN_NEG) begin
                lane_mag[n] = MAG_MAX_POS;
            end else if (lane_mag[n][VALUE_WIDTH-1]) begin
                lane_mag[n] = ~lane_mag[n] + 1'b1;
            end
        end
    end

    // Largest magnitude in the beat. A strict compare keeps the lowest lane on ties.
    always_comb begin
        beat_max  = lane_mag[0];
        beat_lane = '0;
        for (int n = 1; n < NUM_PARALLEL; n++) begin
            if (lane_mag[n] > beat_max) begin
                beat_max  = lane_mag[n];
                beat_lane = LANE_W'(n);
            end
        end
    end

    // Stage 1: register the beat maximum with its base sample index and advance the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            s1_valid   <= 1'b0;
            s1_max     <= '0;
            s1_lane    <= '0;
            s1_base    <= '0;
        end else if (advance) begin
            s1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1_max     <= beat_max;
                s1_lane    <= beat_lane;
                s1_base    <= sample_cnt;
                sample_cnt <= sample_cnt + BEAT_STEP;
            end
        end
    end

    // The index may wrap inside a beat; the sum is taken modulo 2^INDEX_WIDTH.
    assign cand_idx = s1_base + INDEX_WIDTH'(s1_lane);

    // Stage 2: trigger, windowed peak search and dead-time holdoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            dead_cnt <= '0;
            peak_idx <= '0;
            peak_mag <= '0;
            close_q  <= 1'b0;
        end else if (advance) begin
            close_q <= 1'b0;
            if (s1_valid) begin
                case (state)
                    IDLE: begin
                        if (s1_max >= threshold) begin
                            peak_idx <= cand_idx;
                            peak_mag <= s1_max;
                            win_cnt  <= WIN_W'(1);
                            if (SEARCH_BEATS == 1) begin
                                close_q  <= 1'b1;
                                dead_cnt <= '0;
                                state    <= (DEAD_BEATS > 0) ? HOLDOFF : IDLE;
                            end else begin
                                state <= SEARCH;
                            end
                        end
                    end
                    SEARCH: begin
                        win_cnt <= win_cnt + 1'b1;
                        // Strictly greater so the earliest peak survives ties.
                        if (s1_max > peak_mag) begin
                            peak_idx <= cand_idx;
                            peak_mag <= s1_max;
                        end
                        if (win_cnt + 1'b1 == WIN_LAST) begin
                            close_q  <= 1'b1;
                            dead_cnt <= '0;
                            state    <= (DEAD_BEATS > 0) ? HOLDOFF : IDLE;
                        end
                    end
                    HOLDOFF: begin
                        if (dead_cnt == DEAD_LAST) begin
                            state <= IDLE;
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output slot: load the closed window's peak and hold it until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (advance) begin
            if (close_q) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {peak_idx, peak_mag};
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axis_corr_peak.md
Name: axis_corr_peak

Overview:
- Sits directly downstream of the bit correlator. Consumes its packed AXI-stream of NUM_PARALLEL signed correlation samples per beat.
- Computes the saturating magnitude of each sample and detects threshold crossings.
- After a crossing, searches a fixed window for the largest magnitude and emits one report: {sample index, peak magnitude}.
- Reports feed the timing/ranging logic.

Parameters:
- NUM_PARALLEL, 8, samples per beat; power of two.
- SLAVE_WIDTH, 128, input bus width. VALUE_WIDTH = SLAVE_WIDTH/NUM_PARALLEL (16).
- INDEX_WIDTH, 16, sample-index counter width.
- SEARCH_BEATS, 4, window length in accepted beats, including the triggering beat; ≥1.
- DEAD_BEATS, 2, accepted beats ignored after a report; 0 disables holdoff.
- MASTER_WIDTH, derived = INDEX_WIDTH+VALUE_WIDTH, output bus width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- threshold  in  VALUE_WIDTH  unsigned trigger level
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  SLAVE_WIDTH  lane n at bits [n*VALUE_WIDTH +: VALUE_WIDTH], signed
- m_axis_tvalid  out  1  report valid
- m_axis_tready  in  1  report ready
- m_axis_tdata  out  MASTER_WIDTH  {index[INDEX_WIDTH-1:0], magnitude[VALUE_WIDTH-1:0]}

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; sample counter=0; all pipeline valids=0; m_axis_tvalid=0; m_axis_tdata=0; peak regs=0.
- Reset mid-SEARCH or mid-HOLDOFF discards the partial result; no report is emitted.

Flow control:
- advance = ~m_axis_tvalid | m_axis_tready.
- s_axis_tready = advance & ~rst.
- All pipeline stages enable only on advance; the whole pipe stalls while a report is held. No beat is lost or duplicated.

Magnitude:
- |x|, with -2^(VALUE_WIDTH-1) saturating to 2^(VALUE_WIDTH-1)-1.
- Magnitude and threshold are unsigned; crossing condition is magnitude ≥ threshold.

Stage 1 (registered on the accept edge):
- Beat max magnitude and its lane; the lowest lane wins ties.
- Beat base index = sample counter value.
- Sample counter += NUM_PARALLEL per accepted beat, wrapping mod 2^INDEX_WIDTH.

Stage 2 (state machine, updated on the next advancing edge with a stage-1 valid):
- IDLE: if beat max ≥ threshold, latch peak = {base+lane, max}, win_cnt = 1, go to SEARCH. If SEARCH_BEATS = 1, close the window immediately.
- SEARCH: each beat increments win_cnt. Peak updates only on strictly greater magnitude, so the earliest peak wins ties. When win_cnt reaches SEARCH_BEATS on that beat, raise close. Next state is HOLDOFF (dead counter = 0) if DEAD_BEATS > 0, else IDLE.
- HOLDOFF: count DEAD_BEATS beats and ignore their data, then go to IDLE. Evaluation of the beat after the last dead beat happens in IDLE.
- threshold is sampled only during IDLE evaluation.

Output register:
- Loaded on the advancing edge after close; m_axis_tvalid=1.
- tdata is held stable until the tvalid&tready handshake.
- With no new report pending, m_axis_tvalid clears on the handshake.

Latency and widths:
- Latency from the accept edge of the window-closing beat to m_axis_tvalid high is 3 rising edges, counting the accept edge as the 1st, with no backpressure.
- Index arithmetic base+lane is mod 2^INDEX_WIDTH; a wrap inside a beat is allowed.

Test Plan:
(NUM_PARALLEL=8, VALUE_WIDTH=16, threshold=100, SEARCH_BEATS=4, DEAD_BEATS=2, m_axis_tready=1 unless stated)

1. 10 all-zero beats -> no report. Then a beat with lane0=100 (base 80) and three zero beats -> report {80, 100}, since the crossing condition is ≥.
2. Beat 3 lane5=-150, beat 4 lane2=200, all else 0 -> one report {34, 200}. m_axis_tvalid rises on the 3rd edge after beat 6 is accepted.
3. Beat 0 lanes 1 and 6 = 300, beat 2 lane 0 = 300 -> report {1, 300}; ties go to the lowest lane and the earliest beat.
4. Beat 0 lane3 = -32768 -> report {3, 32767}. Beats 4–5 carry 500 and are ignored as holdoff. Beat 6 lane0 = 120 -> report {48, 120}.
5. A report is pending with m_axis_tready=0 for 10 cycles while s_axis_tvalid=1 -> s_axis_tready=0 and tdata stable throughout. After release, the next report's index matches the uninterrupted stream.
6. rst pulsed during SEARCH (after beat 2 of a window) -> no report. Counter restarts: a crossing on the first post-reset beat lane4 -> report {4, value}.
